// File: rtl/delay_unit_pkg.sv
// delay_unit_pkg: shared state encoding and default widths for the trigger delay / pulse train stages
package delay_unit_pkg;
  typedef enum logic [1:0] {PT_IDLE, PT_HIGH, PT_LOW} pt_state_t;
  localparam int PT_WIDTH_BITS = 32;
  localparam int PT_COUNT_BITS = 16;
endpackage

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter with zero flag, shared by the width and gap phases
module pulse_timer
  import delay_unit_pkg::*;
#(
  parameter int WIDTH_BITS = PT_WIDTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  en,
  input  logic [WIDTH_BITS-1:0] load_val,
  output logic                  zero
);
  logic [WIDTH_BITS-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - WIDTH_BITS'(1);
  end
  assign zero = (cnt == '0);
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a width/gap/count pulse train per accepted trigger from shadowed config
module pulse_train_gen
  import delay_unit_pkg::*;
#(
  parameter int WIDTH_BITS = PT_WIDTH_BITS,
  parameter int COUNT_BITS = PT_COUNT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trigger_in,
  input  logic [WIDTH_BITS-1:0] pulse_width,
  input  logic [WIDTH_BITS-1:0] pulse_gap,
  input  logic [COUNT_BITS-1:0] pulse_count,
  input  logic                  cfg_update,
  output logic                  pulse_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);
  pt_state_t st, nxt;
  logic [WIDTH_BITS-1:0] sh_w, sh_g, wk_w, wk_g, load_val, gap_m1;
  logic [COUNT_BITS-1:0] sh_c, left;
  logic load, en, zero, take, dec, done_d, ovr_d;
  assign gap_m1 = (wk_g == '0) ? '0 : wk_g - WIDTH_BITS'(1);
  pulse_timer #(.WIDTH_BITS(WIDTH_BITS)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .en(en), .load_val(load_val), .zero(zero)
  );
  always_comb begin
    nxt = st;
    load = 1'b0;
    en = 1'b0;
    load_val = '0;
    take = 1'b0;
    dec = 1'b0;
    done_d = 1'b0;
    ovr_d = 1'b0;
    case (st)
      PT_IDLE: if (trigger_in) begin
        if (sh_w != '0 && sh_c != '0) begin
          nxt = PT_HIGH;
          load = 1'b1;
          load_val = sh_w - WIDTH_BITS'(1);
          take = 1'b1;
        end else done_d = 1'b1;
      end
      PT_HIGH: begin
        ovr_d = trigger_in;
        if (!zero) en = 1'b1;
        else if (left == '0) begin
          nxt = PT_IDLE;
          done_d = 1'b1;
        end else begin
          nxt = PT_LOW;
          load = 1'b1;
          load_val = gap_m1;
        end
      end
      PT_LOW: begin
        ovr_d = trigger_in;
        if (!zero) en = 1'b1;
        else begin
          nxt = PT_HIGH;
          load = 1'b1;
          load_val = wk_w - WIDTH_BITS'(1);
          dec = 1'b1;
        end
      end
      default: nxt = PT_IDLE;
    endcase
  end
  // working copies isolate a running train from later cfg_update writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= PT_IDLE;
      sh_w <= '0;
      sh_g <= '0;
      sh_c <= '0;
      wk_w <= '0;
      wk_g <= '0;
      left <= '0;
      pulse_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      st <= nxt;
      if (cfg_update) begin
        sh_w <= pulse_width;
        sh_g <= pulse_gap;
        sh_c <= pulse_count;
      end
      if (take) begin
        wk_w <= sh_w;
        wk_g <= sh_g;
        left <= sh_c - COUNT_BITS'(1);
      end else if (dec) left <= left - COUNT_BITS'(1);
      pulse_out <= (nxt == PT_HIGH);
      busy <= (nxt != PT_IDLE);
      done <= done_d;
      overrun <= ovr_d;
    end
  end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: timing-formula model feeding a scoreboard, plus table-driven scenario totals
module tb_pulse_train_gen;
  logic clk = 1'b0, rst_n = 1'b0, trigger_in = 1'b0, cfg_update = 1'b0;
  logic [31:0] pulse_width = '0, pulse_gap = '0;
  logic [15:0] pulse_count = '0;
  logic pulse_out, busy, done, overrun;

  pulse_train_gen dut (
    .clk(clk), .rst_n(rst_n), .trigger_in(trigger_in), .pulse_width(pulse_width),
    .pulse_gap(pulse_gap), .pulse_count(pulse_count), .cfg_update(cfg_update),
    .pulse_out(pulse_out), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {logic p, b, d, o;} exp_t;
  typedef struct {int w, g, c, t2, t3, rises, dones, ovrs;} vec_t;
  exp_t sb[$];
  vec_t vecs[7];
  int checks = 0, passed = 0;
  int rises, highs, dones, ovrs;
  logic prev_p = 1'b0;
  longint e = 0, ts = 0, mw = 0, mg = 0, mc = 0, sw = 0, sg = 0, sc = 0;
  bit act = 0;

  function automatic longint geff();
    return (mg == 0) ? 1 : mg;
  endfunction

  function automatic longint tend();
    return mc * mw + (mc - 1) * geff();
  endfunction

  task automatic chk(input string n, input logic a, input logic x);
    checks++;
    if (a === x) passed++;
    else $display("FAIL %s at edge %0d: got %b expected %b", n, e, a, x);
  endtask

  task automatic chk_int(input string n, input int a, input int x);
    checks++;
    if (a == x) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, a, x);
  endtask

  task automatic clear_stats();
    rises = 0; highs = 0; dones = 0; ovrs = 0;
  endtask

  // model predicts outputs after the next edge from the current inputs, then compares at negedge
  task automatic step();
    exp_t x;
    longint rel;
    bit busy_prev;
    e++;
    x = '{1'b0, 1'b0, 1'b0, 1'b0};
    if (!rst_n) begin
      act = 0; sw = 0; sg = 0; sc = 0;
    end else begin
      busy_prev = act && (e - 1 - ts) >= 0 && (e - 1 - ts) < tend();
      if (trigger_in) begin
        if (busy_prev) x.o = 1'b1;
        else if (sw != 0 && sc != 0) begin
          act = 1; ts = e; mw = sw; mg = sg; mc = sc;
        end else x.d = 1'b1;
      end
      if (act) begin
        rel = e - ts;
        x.b = rel < tend();
        x.p = x.b && (rel % (mw + geff())) < mw;
        if (rel == tend()) x.d = 1'b1;
      end
      if (cfg_update) begin
        sw = longint'(pulse_width); sg = longint'(pulse_gap); sc = longint'(pulse_count);
      end
    end
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    chk("pulse_out", pulse_out, x.p);
    chk("busy", busy, x.b);
    chk("done", done, x.d);
    chk("overrun", overrun, x.o);
    if (pulse_out && !prev_p) rises++;
    if (pulse_out) highs++;
    if (done) dones++;
    if (overrun) ovrs++;
    prev_p = pulse_out;
  endtask

  task automatic load_cfg(input int w, input int g, input int c);
    pulse_width = w; pulse_gap = g; pulse_count = c; cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    step();
  endtask

  task automatic run_vec(input vec_t v);
    load_cfg(v.w, v.g, v.c);
    clear_stats();
    for (int i = 0; i < 30; i++) begin
      trigger_in = (i == 0 || i == v.t2 || i == v.t3);
      step();
    end
    trigger_in = 1'b0;
    chk_int($sformatf("rises w%0d g%0d c%0d", v.w, v.g, v.c), rises, v.rises);
    chk_int($sformatf("dones w%0d g%0d c%0d", v.w, v.g, v.c), dones, v.dones);
    chk_int($sformatf("overruns w%0d g%0d c%0d", v.w, v.g, v.c), ovrs, v.ovrs);
  endtask

  initial begin
    vecs[0] = '{3, 2, 2, -1, -1, 2, 1, 0};
    vecs[1] = '{0, 2, 3, -1, -1, 0, 1, 0};
    vecs[2] = '{3, 1, 0, -1, -1, 0, 1, 0};
    vecs[3] = '{4, 0, 1, 2, 4, 1, 1, 2};
    vecs[4] = '{2, 0, 3, -1, -1, 3, 1, 0};
    vecs[5] = '{1, 1, 1, -1, -1, 1, 1, 0};
    vecs[6] = '{2, 3, 4, 5, -1, 4, 1, 1};
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    foreach (vecs[i]) run_vec(vecs[i]);
    // config written in the trigger cycle applies only to the next train
    load_cfg(2, 1, 1);
    clear_stats();
    pulse_width = 5; cfg_update = 1'b1; trigger_in = 1'b1;
    step();
    cfg_update = 1'b0; trigger_in = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk_int("old shadow width", highs, 2);
    clear_stats();
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk_int("new shadow width", highs, 5);
    // trigger while done is high is accepted
    load_cfg(1, 1, 1);
    clear_stats();
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    step();
    chk("done before retrigger", done, 1'b1);
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_int("retrigger on done rises", rises, 2);
    chk_int("retrigger on done overruns", ovrs, 0);
    // reset mid-train aborts without done and clears the shadow
    load_cfg(10, 1, 1);
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    clear_stats();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk_int("no done after reset abort", dones, 0);
    chk_int("no pulse after reset abort", highs, 0);
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_int("post-reset trigger done", dones, 1);
    chk_int("post-reset trigger rises", rises, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
